// File: rtl/alu_exec_unit_if.sv
// ============================================================================
// Module      : alu_exec_unit_if
// Description : Request/response handshake bundle for the ALU execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             valid_i;
    logic             ready_o;
    logic [1:0]       ALUOp_i;
    logic [9:0]       funct_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             valid_o;
    logic             ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             illegal_o;
    logic             busy_o;

    // Producer/consumer side of the execute stage.
    modport master (
        output valid_i, ALUOp_i, funct_i, data1_i, data2_i, ready_i,
        input  ready_o, valid_o, result_o, zero_o, illegal_o, busy_o
    );

    // Execute stage itself.
    modport slave (
        input  valid_i, ALUOp_i, funct_i, data1_i, data2_i, ready_i,
        output ready_o, valid_o, result_o, zero_o, illegal_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/alu_exec_unit.sv
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute stage: ALU-control decode, one-cycle logic/arith/shift
//               ops and an iterative shift-add multiplier behind valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_STEP = 2
) (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    alu_exec_unit_if.slave   bus
);

    localparam int c_SHW   = $clog2(WIDTH);
    localparam int c_STEPS = WIDTH / MUL_STEP;
    localparam int c_CNT_W = $clog2(c_STEPS + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(c_STEPS);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    // {funct7, funct3} encodings recognised under ALUOp 10
    localparam logic [9:0] c_F_OR  = 10'b0000000_110;
    localparam logic [9:0] c_F_AND = 10'b0000000_111;
    localparam logic [9:0] c_F_ADD = 10'b0000000_000;
    localparam logic [9:0] c_F_SUB = 10'b0100000_000;
    localparam logic [9:0] c_F_MUL = 10'b0000001_000;
    localparam logic [9:0] c_F_XOR = 10'b0000000_100;
    localparam logic [9:0] c_F_SLL = 10'b0000000_001;
    localparam logic [9:0] c_F_SRA = 10'b0100000_101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRA = 4'd6,
        OP_MUL = 4'd7,
        OP_ILL = 4'd8
    } op_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_valid;
    logic               r_illegal;
    logic               r_busy;
    logic               r_ready;

    op_t                w_op;
    logic [c_SHW-1:0]   w_shamt;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_partial;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_accept;

    assign w_accept = bus.valid_i && r_ready;

    always_comb begin
        w_op = OP_ILL;
        case (bus.ALUOp_i)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                case (bus.funct_i)
                    c_F_OR:  w_op = OP_OR;
                    c_F_AND: w_op = OP_AND;
                    c_F_ADD: w_op = OP_ADD;
                    c_F_SUB: w_op = OP_SUB;
                    c_F_MUL: w_op = OP_MUL;
                    c_F_XOR: w_op = OP_XOR;
                    c_F_SLL: w_op = OP_SLL;
                    c_F_SRA: w_op = OP_SRA;
                    default: w_op = OP_ILL;
                endcase
            end
            default: w_op = OP_ILL;
        endcase
    end

    // Single-cycle datapath works straight off the request so the result
    // lands in r_result on the accept edge; illegal encodings yield zero.
    assign w_shamt = bus.data2_i[c_SHW-1:0];

    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = bus.data1_i + bus.data2_i;
            OP_SUB:  w_alu = bus.data1_i - bus.data2_i;
            OP_AND:  w_alu = bus.data1_i & bus.data2_i;
            OP_OR:   w_alu = bus.data1_i | bus.data2_i;
            OP_XOR:  w_alu = bus.data1_i ^ bus.data2_i;
            OP_SLL:  w_alu = bus.data1_i << w_shamt;
            OP_SRA:  w_alu = WIDTH'($signed(bus.data1_i) >>> w_shamt);
            default: w_alu = '0;
        endcase
    end

    // Partial products of the low MUL_STEP multiplier bits; the multiplicand
    // register already carries the shift of all previously retired bits.
    always_comb begin
        w_partial = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (r_mplier[j]) begin
                w_partial = w_partial + (r_mcand << j);
            end
        end
    end

    assign w_acc_next = r_acc + w_partial;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_result  <= '0;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_busy    <= 1'b0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand  <= bus.data1_i;
                        r_mplier <= bus.data2_i;
                        r_busy   <= 1'b1;
                        r_ready  <= 1'b0;
                        if (w_op == OP_MUL) begin
                            r_state <= S_MUL;
                            r_acc   <= '0;
                            r_cnt   <= c_CNT_INIT;
                        end else begin
                            r_state   <= S_DONE;
                            r_result  <= w_alu;
                            r_illegal <= (w_op == OP_ILL);
                            r_valid   <= 1'b1;
                        end
                    end
                end

                S_MUL: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << MUL_STEP;
                    r_mplier <= r_mplier >> MUL_STEP;
                    r_cnt    <= r_cnt - c_CNT_ONE;
                    // Fixed latency: always run all WIDTH/MUL_STEP iterations.
                    if (r_cnt == c_CNT_ONE) begin
                        r_state   <= S_DONE;
                        r_result  <= w_acc_next;
                        r_illegal <= 1'b0;
                        r_valid   <= 1'b1;
                    end
                end

                S_DONE: begin
                    if (r_valid && bus.ready_i) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o   = r_ready;
    assign bus.valid_o   = r_valid;
    assign bus.result_o  = r_result;
    assign bus.zero_o    = (r_result == '0);
    assign bus.illegal_o = r_illegal;
    assign bus.busy_o    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Scoreboard bench for alu_exec_unit at WIDTH=32, MUL_STEP=2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

    localparam int c_W = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    typedef struct {
        logic [c_W-1:0] res;
        logic           ill;
        int             lat;
    } exp_t;

    exp_t sb[$];

    alu_exec_unit_if #(.WIDTH(c_W)) bus ();

    alu_exec_unit #(
        .WIDTH    (c_W),
        .MUL_STEP (2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Golden model: behavioural operators, not the shift-add structure.
    function automatic exp_t model(input logic [1:0] op, input logic [9:0] f,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e.res = '0;
        e.ill = 1'b0;
        e.lat = 1;
        if (op == 2'b00)      e.res = a + b;
        else if (op == 2'b01) e.res = a - b;
        else if (op == 2'b11) e.ill = 1'b1;
        else begin
            case (f)
                10'h006: e.res = a | b;
                10'h007: e.res = a & b;
                10'h000: e.res = a + b;
                10'h100: e.res = a - b;
                10'h008: begin e.res = a * b; e.lat = 17; end
                10'h004: e.res = a ^ b;
                10'h001: e.res = a << b[4:0];
                10'h105: e.res = 32'($signed(a) >>> b[4:0]);
                default: e.ill = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Drive one request, push expectation, wait for valid_o, pop and compare.
    // hold > 0 keeps ready_i low for that many cycles after valid_o appears.
    task automatic issue(input logic [1:0] op, input logic [9:0] f,
                         input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int hold);
        exp_t got_e;
        int   lat;
        bus.ready_i = (hold == 0);
        bus.valid_i = 1'b1;
        bus.ALUOp_i = op;
        bus.funct_i = f;
        bus.data1_i = a;
        bus.data2_i = b;
        tick();
        bus.valid_i = 1'b0;
        bus.data1_i = $urandom;
        bus.data2_i = $urandom;
        sb.push_back(e);
        check("busy_after_accept", bus.busy_o, 1);
        check("ready_after_accept", bus.ready_o, 0);
        lat = 1;
        while (!bus.valid_o && lat < 64) begin
            tick();
            lat++;
        end
        got_e = sb.pop_front();
        check("latency", lat, got_e.lat);
        check("result", bus.result_o, got_e.res);
        check("zero", bus.zero_o, (got_e.res == '0));
        check("illegal", bus.illegal_o, got_e.ill);
        for (int k = 0; k < hold; k++) begin
            tick();
            check("hold_valid", bus.valid_o, 1);
            check("hold_result", bus.result_o, got_e.res);
            check("hold_illegal", bus.illegal_o, got_e.ill);
            check("hold_ready", bus.ready_o, 0);
        end
        bus.ready_i = 1'b1;
        tick();
        check("post_valid", bus.valid_o, 0);
        check("post_ready", bus.ready_o, 1);
        check("post_busy", bus.busy_o, 0);
        check("post_result_kept", bus.result_o, got_e.res);
    endtask

    function automatic exp_t lit(input logic [31:0] r, input logic ill, input int lat);
        exp_t e;
        e.res = r;
        e.ill = ill;
        e.lat = lat;
        return e;
    endfunction

    initial begin
        logic [9:0] legal_f [8];
        logic [1:0] op;
        logic [9:0] f;
        logic [31:0] a;
        logic [31:0] b;
        int seen;

        legal_f = '{10'h006, 10'h007, 10'h000, 10'h100, 10'h008, 10'h004, 10'h001, 10'h105};
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.ALUOp_i = 2'b00;
        bus.funct_i = '0;
        bus.data1_i = '0;
        bus.data2_i = '0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", bus.ready_o, 1);
        check("rst_valid", bus.valid_o, 0);
        check("rst_result", bus.result_o, 0);
        check("rst_zero", bus.zero_o, 1);
        check("rst_busy", bus.busy_o, 0);
        check("rst_illegal", bus.illegal_o, 0);
        tick();
        check("idle_ready", bus.ready_o, 1);

        // Directed cases with hand-derived expectations
        issue(2'b10, 10'h100, 32'd5, 32'd7, lit(32'hFFFF_FFFE, 1'b0, 1), 0);
        issue(2'b00, 10'h3FF, 32'd3, 32'd3, lit(32'd6, 1'b0, 1), 0);
        issue(2'b10, 10'h008, 32'h0001_0003, 32'h0000_0005, lit(32'h0005_000F, 1'b0, 17), 0);
        issue(2'b10, 10'h008, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lit(32'd1, 1'b0, 17), 0);
        issue(2'b10, 10'h008, 32'h0, 32'h1234, lit(32'd0, 1'b0, 17), 0);
        issue(2'b10, 10'h105, 32'h8000_0000, 32'h24, lit(32'hF800_0000, 1'b0, 1), 0);
        issue(2'b10, 10'h001, 32'd1, 32'd31, lit(32'h8000_0000, 1'b0, 1), 0);
        issue(2'b10, 10'h006, 32'hF0F0_0000, 32'h0000_0F0F, lit(32'hF0F0_0F0F, 1'b0, 1), 0);
        issue(2'b10, 10'h007, 32'hFF00_FF00, 32'h0FF0_0FF0, lit(32'h0F00_0F00, 1'b0, 1), 0);
        issue(2'b10, 10'h004, 32'hAAAA_5555, 32'hFFFF_FFFF, lit(32'h5555_AAAA, 1'b0, 1), 0);
        issue(2'b01, 10'h000, 32'd9, 32'd9, lit(32'd0, 1'b0, 1), 0);
        issue(2'b10, 10'h002, 32'd1, 32'd2, lit(32'd0, 1'b1, 1), 0);

        // Illegal ALUOp under backpressure
        issue(2'b11, 10'h000, 32'd12, 32'd34, lit(32'd0, 1'b1, 1), 5);

        // Randomised ops against the model
        for (int i = 0; i < 16; i++) begin
            op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) begin
                op = 2'b10;
                f  = legal_f[$urandom_range(0, 7)];
            end else begin
                f = 10'($urandom);
            end
            a = $urandom;
            b = $urandom;
            issue(op, f, a, b, model(op, f, a, b), (i % 5 == 4) ? 2 : 0);
        end

        // Reset eight cycles into a MUL discards it
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.ALUOp_i = 2'b10;
        bus.funct_i = 10'h008;
        bus.data1_i = 32'd7;
        bus.data2_i = 32'd9;
        tick();
        bus.valid_i = 1'b0;
        check("mul_busy", bus.busy_o, 1);
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", bus.ready_o, 1);
        check("midrst_valid", bus.valid_o, 0);
        check("midrst_busy", bus.busy_o, 0);
        check("midrst_result", bus.result_o, 0);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (bus.valid_o) seen++;
            tick();
        end
        check("midrst_no_valid", seen, 0);
        issue(2'b00, 10'h000, 32'd1, 32'd1, lit(32'd2, 1'b0, 1), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Parametrised execute stage for the next-generation CPU datapath.
- Merges ALU-control decode (ALUOp + funct7/funct3) with the arithmetic itself.
- Logical, add, subtract and shift operations complete in one registered cycle.
- MUL runs as an iterative multi-cycle shift-add multiplier behind a valid/ready handshake, so the pipeline can stall on it.

Parameters:
- WIDTH, 32: operand and result width; power of two, ≥ 8.
- MUL_STEP, 2: multiplier bits retired per cycle; must divide WIDTH.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  operation request.
- ready_o  output  1  unit can accept a request this cycle.
- ALUOp_i  input  2  00 = ADD (load/store address), 01 = SUB (branch compare), 10 = R-type funct decode, 11 = reserved.
- funct_i  input  10  {funct7, funct3}.
- data1_i  input  WIDTH  operand A.
- data2_i  input  WIDTH  operand B / shift amount.
- valid_o  output  1  result available.
- ready_i  input  1  consumer accepts result.
- result_o  output  WIDTH  result.
- zero_o  output  1  result_o == 0.
- illegal_o  output  1  undefined encoding; qualified by valid_o.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset: synchronous, active-high. Outputs reset to
  - state = IDLE;
  - valid_o, illegal_o, busy_o = 0;
  - result_o = 0, so zero_o = 1;
  - ready_o = 1 from the first cycle after reset.
- States:
  - IDLE: ready_o = 1.
  - MUL: iterating.
  - DONE: valid_o = 1, outputs held stable.
- Accept: a request is taken when valid_i && ready_o on a clock edge. Operands and the decoded op are captured into internal registers. valid_i while not ready is ignored; the producer holds its request.
- ALUOp 10 decode (funct_i):
  - 0000000_110 = OR
  - 0000000_111 = AND
  - 0000000_000 = ADD
  - 0100000_000 = SUB
  - 0000001_000 = MUL
  - 0000000_100 = XOR
  - 0000000_001 = SLL
  - 0100000_101 = SRA
  - Any other encoding is illegal.
- ALUOp 11 is always illegal.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
  - Shift amount = data2_i[log2(WIDTH)-1:0].
  - SRA replicates data1_i[WIDTH-1].
  - MUL returns the low WIDTH bits of the product; signed and unsigned results coincide.
- Single-cycle ops and illegal encodings:
  - IDLE -> DONE on accept.
  - valid_o rises on the edge after accept (latency 1).
  - Illegal: result_o = 0, illegal_o = 1.
- MUL:
  - IDLE -> MUL on accept. Accumulator cleared; multiplier shift register loaded with data2_i; counter = WIDTH/MUL_STEP.
  - Each MUL cycle: add the partial products of the low MUL_STEP multiplier bits to the accumulator; shift the multiplicand left by MUL_STEP and the multiplier right by MUL_STEP; decrement the counter.
  - On the cycle the counter reaches 1, go to DONE.
  - Latency from accept edge to valid_o = WIDTH/MUL_STEP + 1 cycles; 17 at the defaults.
  - Optional early termination is not allowed; latency is fixed.
- DONE:
  - Holds result_o, zero_o, illegal_o until valid_o && ready_i.
  - On that edge: go to IDLE, valid_o = 0. result_o keeps its last value.
  - No same-cycle re-accept; the next request is accepted one cycle later. Maximum throughput is one op per 2 cycles.
- zero_o is combinational from registered result_o.
- rst_i wins over every other event. Asserted during MUL or DONE, the op is discarded, no valid_o is issued, and the unit is back in IDLE the next cycle.
- Backpressure: ready_i low in DONE stalls indefinitely with outputs unchanged.

Test Plan:
- Reset then idle: rst_i high 2 cycles -> ready_o=1, valid_o=0, result_o=0, zero_o=1, busy_o=0.
- ALUOp=10, funct=0100000_000, A=5, B=7 -> valid_o one cycle after accept, result_o=0xFFFFFFFE, zero_o=0. Repeat with ALUOp=00, A=B=3 -> result_o=6.
- MUL: A=0x0001_0003, B=0x0000_0005 -> valid_o exactly 17 cycles after accept, result_o=0x0005_000F. A=0xFFFFFFFF, B=0xFFFFFFFF -> result_o=1. A=0, B=0x1234 -> zero_o=1.
- Shifts: SRA A=0x8000_0000, B=0x24 -> result_o=0xF800_0000 (amount 4). SLL A=1, B=31 -> 0x8000_0000.
- Illegal/backpressure: ALUOp=11 -> illegal_o=1, result_o=0. Hold ready_i=0 for 5 cycles -> valid_o and result stay stable and ready_o stays 0. Raise ready_i -> IDLE the next cycle.
- Reset mid-MUL: assert rst_i 8 cycles after a MUL accept -> no valid_o pulse, ready_o=1 the cycle after reset. A following ADD A=1, B=1 -> result_o=2.
